// File: rtl/i2s_tx_sequencer_if.sv
// Control/FIFO-side signal bundle for the I2S transmit sequencer.
// The master side is the register block plus TxFIFO status; the slave side is the sequencer.
interface i2s_tx_sequencer_if;
  logic        start;
  logic        stop_req;
  logic        frame16;
  logic        fifo_empty;
  logic        clr_underrun;
  logic        rd_en;
  logic        ws;
  logic        busy;
  logic        underrun;
  logic [15:0] frame_cnt;

  modport master (
    output start, stop_req, frame16, fifo_empty, clr_underrun,
    input  rd_en, ws, busy, underrun, frame_cnt
  );

  modport slave (
    input  start, stop_req, frame16, fifo_empty, clr_underrun,
    output rd_en, ws, busy, underrun, frame_cnt
  );
endinterface

// File: rtl/i2s_tx_sequencer.sv
// sclk-domain I2S transmit sequencer: stereo framing, FIFO bit-read enable, word select.
// Define I2S_WS_DELAY_EN for Philips timing (ws leads MSB by one bit); default is left-justified.
module i2s_tx_sequencer (
  input  logic               clk,
  input  logic               rst_,
  i2s_tx_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [4:0]  maxp_q, maxp_d;
  logic [4:0]  bcnt_q, bcnt_d;
  logic        ch_q, ch_d;
  logic        stop_pend_q, stop_pend_d;
  logic        rd_en_q, rd_en_d;
  logic        ws_q, ws_d;
  logic        busy_q, busy_d;
  logic        underrun_q, underrun_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic active, word_end, frame_end, urun_set;

  // bcnt/ch describe the bit that the output registers present on the next cycle.
  always_comb begin
    state_d     = state_q;
    maxp_d      = maxp_q;
    bcnt_d      = bcnt_q;
    ch_d        = ch_q;
    stop_pend_d = stop_pend_q;
    rd_en_d     = 1'b0;
    ws_d        = 1'b0;
    frame_cnt_d = frame_cnt_q;
    urun_set    = 1'b0;

    active    = (state_q == RUN) || (state_q == DRAIN);
    word_end  = (bcnt_q == 5'd0);
    frame_end = word_end && ch_q;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop_req && !bus.fifo_empty) begin
          maxp_d  = bus.frame16 ? 5'd15 : 5'd31;
          state_d = ARM;
        end
      end
      ARM: begin
        bcnt_d      = maxp_q;
        ch_d        = 1'b0;
        stop_pend_d = 1'b0;
        state_d     = RUN;
      end
      RUN: begin
        if (bus.stop_req || stop_pend_q) begin
          stop_pend_d = 1'b1;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        if (frame_end)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (active) begin
      rd_en_d = 1'b1;
      if (word_end) begin
        bcnt_d = maxp_q;
        ch_d   = ~ch_q;
      end else begin
        bcnt_d = bcnt_q - 5'd1;
      end
`ifdef I2S_WS_DELAY_EN
      // Flip on the LSB, except the last LSB of a drain which holds right.
      if (word_end && !(state_q == DRAIN && ch_q))
        ws_d = ~ch_q;
      else
        ws_d = ch_q;
`else
      ws_d = ch_q;
`endif
      if (frame_end)
        frame_cnt_d = frame_cnt_q + 16'd1;
      if ((bcnt_q == maxp_q) && bus.fifo_empty)
        urun_set = 1'b1;
    end

    if (urun_set)
      underrun_d = 1'b1;
    else if (bus.clr_underrun)
      underrun_d = 1'b0;
    else
      underrun_d = underrun_q;

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q     <= IDLE;
      maxp_q      <= 5'd31;
      bcnt_q      <= 5'd0;
      ch_q        <= 1'b0;
      stop_pend_q <= 1'b0;
      rd_en_q     <= 1'b0;
      ws_q        <= 1'b0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      maxp_q      <= maxp_d;
      bcnt_q      <= bcnt_d;
      ch_q        <= ch_d;
      stop_pend_q <= stop_pend_d;
      rd_en_q     <= rd_en_d;
      ws_q        <= ws_d;
      busy_q      <= busy_d;
      underrun_q  <= underrun_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.rd_en     = rd_en_q;
  assign bus.ws        = ws_q;
  assign bus.busy      = busy_q;
  assign bus.underrun  = underrun_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// Self-checking bench for i2s_tx_sequencer: each start pushes the expected rd_en burst
// (word width, length) to a scoreboard; a negedge monitor checks bursts and ws per bit.
module tb_i2s_tx_sequencer;

  logic clk = 1'b0;
  logic rst_;
  always #5 clk = ~clk;

  i2s_tx_sequencer_if bus ();

  i2s_tx_sequencer dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  typedef struct {
    int w;
    int len;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   exp_fc = 0;
  int   idle_ws_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected ws at bit offset i of a burst with word width w and total length len.
  function automatic logic exp_ws(input int i, input int w, input int len);
`ifdef I2S_WS_DELAY_EN
    if ((i == len - 1) && (len % (2 * w) == 0)) return 1'b1;
    return 1'(((i + 1) / w) % 2);
`else
    return 1'((i / w) % 2);
`endif
  endfunction

  // Burst monitor
  logic in_burst = 1'b0;
  int   blen = 0;
  int   werr = 0;
  exp_t cur;

  always @(negedge clk) begin
    if (bus.rd_en === 1'b1) begin
      if (!in_burst) begin
        in_burst = 1'b1;
        blen = 0;
        werr = 0;
        if (sb.size() == 0) begin
          chk("sb_unexpected_burst", 1, 0);
          cur.w = 16;
          cur.len = 0;
        end else begin
          cur = sb.pop_front();
        end
      end
      if (bus.ws !== exp_ws(blen, cur.w, cur.len)) werr++;
      blen++;
    end else begin
      if (in_burst) begin
        in_burst = 1'b0;
        chk("burst_len", blen, cur.len);
        chk("ws_pattern_errs", werr, 0);
      end
      if (bus.ws !== 1'b0) idle_ws_err++;
    end
  end

  // Issue start and check the two-cycle latency; returns on the cycle of bit 0.
  task automatic start_run(input int w, input int len);
    sb.push_back('{w, len});
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    chk("lat_n0_rd_en", bus.rd_en, 0);
    chk("arm_busy", bus.busy, 1);
    tick(1);
    chk("lat_n1_rd_en", bus.rd_en, 0);
    tick(1);
    chk("lat_n2_rd_en", bus.rd_en, 1);
    chk("first_ws_left", bus.ws, 0);
  endtask

  task automatic stop_and_wait();
    bus.stop_req = 1'b1;
    tick(1);
    bus.stop_req = 1'b0;
    for (int k = 0; k < 400 && bus.busy; k++) tick(1);
    chk("idle_reached", bus.busy, 0);
    tick(1);
    chk("rd_en_after_stop", bus.rd_en, 0);
    chk("frame_cnt", bus.frame_cnt, exp_fc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_             = 1'b0;
    bus.start        = 1'b0;
    bus.stop_req     = 1'b0;
    bus.frame16      = 1'b0;
    bus.fifo_empty   = 1'b0;
    bus.clr_underrun = 1'b0;
    tick(2);
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_ws", bus.ws, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_underrun", bus.underrun, 0);
    chk("rst_frame_cnt", bus.frame_cnt, 0);
    rst_ = 1'b1;
    tick(2);

    // 32-bit words, stop during right word of frame 3: 3 frames, 192 bits
    bus.frame16 = 1'b0;
    start_run(32, 192);
    tick(169);
    exp_fc += 3;
    stop_and_wait();

    // 16-bit, frame16 toggled mid-run must not change the width
    bus.frame16 = 1'b1;
    start_run(16, 64);
    tick(5);
    bus.frame16 = 1'b0;
    tick(35);
    exp_fc += 2;
    stop_and_wait();

    // restart picks up the new 32-bit width
    start_run(32, 64);
    tick(9);
    exp_fc += 1;
    stop_and_wait();

    // start while FIFO empty is ignored
    bus.frame16 = 1'b1;
    bus.fifo_empty = 1'b1;
    bus.start = 1'b1;
    tick(3);
    chk("empty_start_busy", bus.busy, 0);
    chk("empty_start_rd_en", bus.rd_en, 0);
    bus.start = 1'b0;
    tick(2);
    chk("empty_start_busy2", bus.busy, 0);
    bus.fifo_empty = 1'b0;
    tick(1);
    start_run(16, 32);
    exp_fc += 1;
    stop_and_wait();

    // underrun at right-word MSB (bit 16), sticky against same-cycle clear
    start_run(16, 64);
    tick(14);
    bus.fifo_empty = 1'b1;
    tick(4);
    bus.fifo_empty = 1'b0;
    tick(1);
    chk("underrun_set", bus.underrun, 1);
    tick(11);
    bus.fifo_empty = 1'b1;
    tick(1);
    bus.clr_underrun = 1'b1;
    tick(1);
    bus.clr_underrun = 1'b0;
    bus.fifo_empty = 1'b0;
    tick(1);
    chk("underrun_set_wins", bus.underrun, 1);
    tick(7);
    bus.clr_underrun = 1'b1;
    tick(1);
    bus.clr_underrun = 1'b0;
    chk("underrun_cleared", bus.underrun, 0);
    exp_fc += 2;
    stop_and_wait();

    // asynchronous reset mid right word
    start_run(16, 20);
    tick(20);
    chk("pre_rst_ws", bus.ws, 1);
    rst_ = 1'b0;
    #1;
    chk("arst_rd_en", bus.rd_en, 0);
    chk("arst_ws", bus.ws, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_frame_cnt", bus.frame_cnt, 0);
    exp_fc = 0;
    tick(2);
    rst_ = 1'b1;
    tick(5);
    chk("post_rst_busy", bus.busy, 0);
    chk("post_rst_rd_en", bus.rd_en, 0);

    start_run(16, 32);
    exp_fc += 1;
    stop_and_wait();

    tick(3);
    chk("idle_ws_errs", idle_ws_err, 0);
    chk("sb_leftover", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_tx_sequencer.md
# i2s_tx_sequencer

Serial-clock-domain controller that sequences the transmit FIFO's serial read side and generates the I2S word-select line. It runs one stereo frame at a time (left word, then right word), drives the FIFO bit-read enable, and tracks bit and word position for 16- or 32-bit words. It starts cleanly on command, stops only on a stereo-frame boundary, and flags underruns. It sits between the control register block and the TxFIFO/serializer on the `sclk` side.

## Interface
- No parameters; word length is selected at run time by `frame16`.
- `clk` in 1: serial bit clock (sclk); all logic on posedge.
- `rst_` in 1: one clock; reset is asynchronous and active-low.
- `start` in 1: level or pulse; request to begin transmission.
- `stop_req` in 1: pulse; request to stop at the next stereo-frame end.
- `frame16` in 1: 1 = 16-bit words, 0 = 32-bit words.
- `fifo_empty` in 1: TxFIFO empty flag, already in the `clk` domain.
- `clr_underrun` in 1: pulse; clears `underrun`.
- `rd_en` out 1: bit-read enable to the TxFIFO.
- `ws` out 1: I2S word select; 0 = left, 1 = right.
- `busy` out 1: high in ARM, RUN and DRAIN.
- `underrun` out 1: sticky underrun flag.
- `frame_cnt` out 16: count of completed stereo frames; wraps.

## Operation
- Internal state: `maxp` is latched to 15 or 31 from `frame16`. `bcnt` is 5 bits. `ch` is 1 bit. `stop_pend` is 1 bit.
- FSM states: IDLE, ARM, RUN, DRAIN.
- IDLE
  - `rd_en`=0, `ws`=0, `busy`=0.
  - On `start` && !`stop_req` && !`fifo_empty`: latch `maxp` from `frame16`, go to ARM.
  - `start` while `fifo_empty`=1 is ignored and the FSM stays in IDLE.
- ARM
  - Lasts exactly one cycle.
  - `bcnt`<=`maxp`, `ch`<=0, `rd_en`=0, `stop_pend`<=0.
  - Go to RUN.
- RUN
  - `rd_en`=1 every cycle.
  - `bcnt` decrements each cycle. When `bcnt`==0 it reloads `maxp` and `ch` toggles.
  - `frame16` changes are ignored until the next pass through IDLE.
  - A `stop_req` pulse sets `stop_pend` and moves the FSM to DRAIN.
- DRAIN
  - Same as RUN, continuing the current frame.
  - At `bcnt`==0 && `ch`==1, go to IDLE. `rd_en` and `ws` are 0 from the next cycle.
  - Further `stop_req` pulses in DRAIN have no effect.
- `frame_cnt` increments at every `bcnt`==0 && `ch`==1 in RUN or DRAIN, and wraps 0xFFFF -> 0.
- Underrun
  - Checked in RUN and DRAIN at a word's first bit (`bcnt`==`maxp`) with `fifo_empty`=1.
  - Sets `underrun`. Transmission continues and framing is preserved.
  - If set and `clr_underrun` occur in the same cycle, set wins.
- `start` in any state other than IDLE is ignored.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. No frame completion is attempted.

## Timing
- Reset values: `rd_en`=0, `ws`=0, `busy`=0, `underrun`=0, `frame_cnt`=0, FSM=IDLE.
- All outputs are registered.
- Start latency: `start` is sampled at edge N; ARM runs N+1..N+2; `rd_en`=1 from edge N+2.
- First word is left.
- One stereo frame = 2×(`maxp`+1) cycles: 32 cycles for 16-bit words, 64 for 32-bit words.
- `ws` timing is set by the configuration macro (below).
- Stop: after the final right-channel LSB cycle, `rd_en` falls on the next edge. No partial frame is ever emitted.

## Configuration
- `I2S_WS_DELAY_EN` defined (Philips I2S)
  - `ws` changes one cycle before a word's MSB, i.e. on the previous word's LSB cycle (`bcnt`==0).
  - In DRAIN, the final LSB keeps `ws`=1, then `ws` goes to 0 in IDLE.
- `I2S_WS_DELAY_EN` undefined (left-justified)
  - `ws` changes on the same cycle as the MSB, so `ws` equals `ch`.

## Test plan
- Reset with `frame16`=1, `fifo_empty`=0, then pulse `start` -> `rd_en` high 2 cycles later. `ws` period is 32 cycles: 16 low, 16 high, with the edge position per macro.
- `frame16`=0, run 3 frames, pulse `stop_req` at cycle 10 of the right word -> FSM exits after that word's LSB. `frame_cnt`=3. `rd_en` is high for exactly 192 cycles.
- `start` with `fifo_empty`=1 -> stays IDLE, `busy`=0. Deassert `fifo_empty`, `start` again -> normal start.
- In RUN, drive `fifo_empty`=1 across a word's first bit -> `underrun`=1 and framing is unchanged. Pulse `clr_underrun` while still empty at the next word start -> `underrun` stays 1. Clear when not empty -> 0.
- Toggle `frame16` mid-RUN -> period unchanged. After stop and restart, the new width applies.
- Assert `rst_`=0 mid-word -> all outputs 0 asynchronously. After release, stays IDLE until `start`.
